// File: rtl/click_classifier_pkg.sv
// click_classifier_pkg
//   Shared definitions for the click classifier and its helpers.
//   click_state_t  : sequence FSM states (IDLE, COUNTING)
//   CLICK_COUNT_W  : width of the click counter / count_o bus
package click_classifier_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      COUNTING = 1'b1
   } click_state_t;

   localparam int CLICK_COUNT_W = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//   Brings an asynchronous level (e.g. a debounced button) into the clk
//   domain through two flops, then emits a one-cycle pulse on each rising
//   edge of the synchronized level. Edge-to-pulse latency is 3 clk.
//   A level that is already high when reset releases does not produce a
//   pulse; the input must be seen low first.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   din    in   asynchronous level input
//   pulse  out  registered one-cycle rising-edge pulse
module sync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic       meta_reg;
   logic       sync_reg;
   logic       prev_reg;
   logic [1:0] fill_reg;   // marks when sync_reg carries a real sample
   logic       armed_reg;  // set once a genuine low has been seen
   logic       pulse_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_reg  <= 1'b0;
         sync_reg  <= 1'b0;
         prev_reg  <= 1'b0;
         fill_reg  <= 2'b00;
         armed_reg <= 1'b0;
         pulse_reg <= 1'b0;
      end else begin
         meta_reg  <= din;
         sync_reg  <= meta_reg;
         prev_reg  <= sync_reg;
         fill_reg  <= {fill_reg[0], 1'b1};
         // The reset value of sync_reg is not a real sample, so only a low
         // observed after the pipeline has filled may arm the detector.
         armed_reg <= armed_reg | (fill_reg[1] & ~sync_reg);
         pulse_reg <= sync_reg & ~prev_reg & armed_reg;
      end
   end

   assign pulse = pulse_reg;

endmodule

// File: rtl/click_classifier.sv
// click_classifier
//   Groups button presses into single / double / triple clicks. A sequence
//   opens on the first press event and stays open while further presses
//   arrive within WINDOW_CYCLES of the previous one. The third click closes
//   the sequence at once; otherwise the window expiring closes it.
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   press_in  in   debounced press level, asynchronous to clk
//   single_o  out  one-cycle pulse: one click classified
//   double_o  out  one-cycle pulse: two clicks classified
//   triple_o  out  one-cycle pulse: three clicks classified
//   busy_o    out  sequence open (held through its closing pulse)
//   count_o   out  clicks accumulated in the open sequence, 0 when idle
module click_classifier
   import click_classifier_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int WINDOW_MS  = 400,
   parameter int MAX_CLICKS = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     press_in,
   output logic                     single_o,
   output logic                     double_o,
   output logic                     triple_o,
   output logic                     busy_o,
   output logic [CLICK_COUNT_W-1:0] count_o
);

   localparam int WINDOW_CYCLES = CLK_FREQ / 1000 * WINDOW_MS;
   localparam int TIMER_W       = $clog2(WINDOW_CYCLES);
   localparam logic [TIMER_W-1:0]       TIMER_LOAD = TIMER_W'(WINDOW_CYCLES - 1);
   localparam logic [CLICK_COUNT_W-1:0] LAST_ADD   = CLICK_COUNT_W'(MAX_CLICKS - 1);

   logic press_event;

   sync_edge_detect u_sync_edge_detect (
      .clk   (clk),
      .reset (reset),
      .din   (press_in),
      .pulse (press_event)
   );

   click_state_t             state_reg,  state_next;
   logic [CLICK_COUNT_W-1:0] count_reg,  count_next;
   logic [TIMER_W-1:0]       timer_reg,  timer_next;
   logic                     single_reg, single_next;
   logic                     double_reg, double_next;
   logic                     triple_reg, triple_next;
   logic                     busy_reg,   busy_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         timer_reg  <= '0;
         single_reg <= 1'b0;
         double_reg <= 1'b0;
         triple_reg <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         timer_reg  <= timer_next;
         single_reg <= single_next;
         double_reg <= double_next;
         triple_reg <= triple_next;
         busy_reg   <= busy_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      timer_next  = timer_reg;
      single_next = 1'b0;
      double_next = 1'b0;
      triple_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (press_event) begin
               state_next = COUNTING;
               count_next = CLICK_COUNT_W'(1);
               timer_next = TIMER_LOAD;
            end
         end
         COUNTING: begin
            // A press arriving together with timer==0 is still inside the
            // window, so the event branch is checked first.
            if (press_event) begin
               if (count_reg == LAST_ADD) begin
                  triple_next = 1'b1;
                  count_next  = '0;
                  timer_next  = '0;
                  state_next  = IDLE;
               end else begin
                  count_next = count_reg + CLICK_COUNT_W'(1);
                  timer_next = TIMER_LOAD;
               end
            end else if (timer_reg == '0) begin
               single_next = (count_reg == CLICK_COUNT_W'(1));
               double_next = (count_reg == CLICK_COUNT_W'(2));
               count_next  = '0;
               state_next  = IDLE;
            end else begin
               timer_next = timer_reg - TIMER_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
            timer_next = '0;
         end
      endcase

      // busy spans the open sequence plus the cycle of its closing pulse.
      busy_next = (state_next == COUNTING) | single_next | double_next | triple_next;
   end

   assign single_o = single_reg;
   assign double_o = double_reg;
   assign triple_o = triple_reg;
   assign busy_o   = busy_reg;
   assign count_o  = count_reg;

endmodule

// File: tb/tb_click_classifier.sv
// tb_click_classifier
//   Self-checking bench for click_classifier with a 10-cycle window.
//   Expected pulses come from an event-level model: each press rise gives
//   an event 3 clk later; events at most WINDOW apart share a sequence;
//   a third event closes it 1 clk later, otherwise it closes WINDOW+1 clk
//   after its last event. Pulses are encoded as cycle*4 + kind
//   (kind 1 single, 2 double, 3 triple).
module tb_click_classifier;

   localparam int WIN = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       press_in;
   logic       single_o;
   logic       double_o;
   logic       triple_o;
   logic       busy_o;
   logic [1:0] count_o;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int busy_cnt = 0;
   int multi_hot = 0;
   int evt_q[$];
   int exp_q[$];
   int obs_q[$];

   click_classifier #(
      .CLK_FREQ   (1000),
      .WINDOW_MS  (10),
      .MAX_CLICKS (3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .press_in (press_in),
      .single_o (single_o),
      .double_o (double_o),
      .triple_o (triple_o),
      .busy_o   (busy_o),
      .count_o  (count_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (single_o) obs_q.push_back(cyc * 4 + 1);
      if (double_o) obs_q.push_back(cyc * 4 + 2);
      if (triple_o) obs_q.push_back(cyc * 4 + 3);
      if (busy_o) busy_cnt <= busy_cnt + 1;
      if ((int'(single_o) + int'(double_o) + int'(triple_o)) > 1) multi_hot <= multi_hot + 1;
   end

   // Reference model: group event cycles into classified pulses.
   function automatic void build_expected();
      int n = 0;
      int last = 0;
      exp_q.delete();
      foreach (evt_q[i]) begin
         int c = evt_q[i];
         if (n > 0 && (c - last) > WIN) begin
            exp_q.push_back((last + WIN + 1) * 4 + n);
            n = 0;
         end
         n++;
         last = c;
         if (n == 3) begin
            exp_q.push_back((c + 1) * 4 + 3);
            n = 0;
         end
      end
      if (n > 0) exp_q.push_back((last + WIN + 1) * 4 + n);
   endfunction

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic press_at(input int k, input int w);
      wait_until(k);
      press_in = 1'b1;
      evt_q.push_back(k + 3);
      wait_until(k + w);
      press_in = 1'b0;
   endtask

   task automatic clear_logs();
      evt_q.delete();
      obs_q.delete();
      busy_cnt = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      press_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (single_o !== 1'b0) begin errors++; $display("FAIL reset_single got %b need 0", single_o); end
      checks++; if (double_o !== 1'b0) begin errors++; $display("FAIL reset_double got %b need 0", double_o); end
      checks++; if (triple_o !== 1'b0) begin errors++; $display("FAIL reset_triple got %b need 0", triple_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b need 0", busy_o); end
      checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL reset_count got %0d need 0", count_o); end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_single();
      int k;
      clear_logs();
      k = cyc + 2;
      press_at(k, 5);
      checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL single_count got %0d need 1", count_o); end
      wait_until(k + 30);
      checks++; if (busy_cnt !== 11) begin errors++; $display("FAIL single_busy_len got %0d need 11", busy_cnt); end
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== (k + 14) * 4 + 1) begin
         errors++;
         $display("FAIL single_pulse got %0d pulses first %0d need cyc %0d kind 1", obs_q.size(),
                  (obs_q.size() > 0) ? obs_q[0] : -1, k + 14);
      end
      $display("test_single rise %0d single expected at %0d", k, k + 14);
   endtask

   task automatic test_double();
      int k;
      clear_logs();
      k = cyc + 2;
      press_at(k, 3);
      wait_until(k + 4);
      checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL double_count1 got %0d need 1", count_o); end
      press_at(k + 6, 3);
      wait_until(k + 10);
      checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL double_count2 got %0d need 2", count_o); end
      wait_until(k + 40);
      build_expected();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL double_npulse got %0d need %0d", obs_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL double_pulse[%0d] got cyc %0d kind %0d need cyc %0d kind %0d", i,
                     obs_q[i] / 4, obs_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
         end
      end
      $display("test_double rises %0d %0d", k, k + 6);
   endtask

   task automatic test_triple();
      int k;
      clear_logs();
      k = cyc + 2;
      press_at(k, 3);
      press_at(k + 6, 3);
      press_at(k + 12, 3);
      wait_until(k + 16);
      checks++; if (triple_o !== 1'b1) begin errors++; $display("FAIL triple_now got %b need 1", triple_o); end
      wait_until(k + 17);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL triple_busy_after got %b need 0", busy_o); end
      wait_until(k + 40);
      build_expected();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL triple_npulse got %0d need %0d", obs_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL triple_pulse[%0d] got cyc %0d kind %0d need cyc %0d kind %0d", i,
                     obs_q[i] / 4, obs_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
         end
      end
      $display("test_triple rises %0d %0d %0d", k, k + 6, k + 12);
   endtask

   task automatic test_coincide();
      int k;
      clear_logs();
      k = cyc + 2;
      // Second event lands exactly when the timer has reached zero.
      press_at(k, 3);
      press_at(k + WIN, 3);
      wait_until(k + 45);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== (k + 3 + WIN + WIN + 1) * 4 + 2) begin
         errors++;
         $display("FAIL coincide_pulse got %0d pulses first %0d need cyc %0d kind 2", obs_q.size(),
                  (obs_q.size() > 0) ? obs_q[0] : -1, k + 3 + WIN + WIN + 1);
      end
      $display("test_coincide rises %0d %0d", k, k + WIN);
   endtask

   task automatic test_reset_mid();
      int k;
      clear_logs();
      k = cyc + 2;
      press_at(k, 3);
      wait_until(k + 7);
      reset = 1'b1;
      wait_until(k + 10);
      reset = 1'b0;
      wait_until(k + 40);
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL resetmid_pulses got %0d need 0", obs_q.size()); end
      checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL resetmid_count got %0d need 0", count_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL resetmid_busy got %b need 0", busy_o); end
      clear_logs();
      k = cyc + 2;
      press_at(k, 4);
      wait_until(k + 30);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== (k + 14) * 4 + 1) begin
         errors++;
         $display("FAIL resetmid_fresh got %0d pulses first %0d need cyc %0d kind 1", obs_q.size(),
                  (obs_q.size() > 0) ? obs_q[0] : -1, k + 14);
      end
      $display("test_reset_mid fresh rise %0d", k);
   endtask

   task automatic test_hold();
      int k;
      clear_logs();
      k = cyc + 2;
      press_at(k, 50);
      wait_until(k + 70);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== (k + 14) * 4 + 1) begin
         errors++;
         $display("FAIL hold_pulse got %0d pulses first %0d need cyc %0d kind 1", obs_q.size(),
                  (obs_q.size() > 0) ? obs_q[0] : -1, k + 14);
      end
      // Press already high when reset releases: nothing until a new rise.
      clear_logs();
      k = cyc + 2;
      wait_until(k);
      reset = 1'b1;
      press_in = 1'b1;
      wait_until(k + 3);
      reset = 1'b0;
      wait_until(k + 43);
      press_in = 1'b0;
      wait_until(k + 63);
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL hold_release_pulses got %0d need 0", obs_q.size()); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL hold_release_busy got %b need 0", busy_o); end
      clear_logs();
      k = cyc + 2;
      press_at(k, 3);
      wait_until(k + 30);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== (k + 14) * 4 + 1) begin
         errors++;
         $display("FAIL hold_rearm got %0d pulses first %0d need cyc %0d kind 1", obs_q.size(),
                  (obs_q.size() > 0) ? obs_q[0] : -1, k + 14);
      end
      $display("test_hold done");
   endtask

   task automatic test_random();
      int k;
      int gap;
      int w;
      clear_logs();
      k = cyc + 2;
      for (int n = 0; n < 80; n++) begin
         gap = ($urandom_range(0, 5) == 0) ? $urandom_range(11, 20) : $urandom_range(5, 11);
         w = $urandom_range(2, gap - 3);
         press_at(k, w);
         k = k + gap;
      end
      wait_until(k + WIN + 10);
      build_expected();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL random_npulse got %0d need %0d", obs_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL random_pulse[%0d] got cyc %0d kind %0d need cyc %0d kind %0d", i,
                     obs_q[i] / 4, obs_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
         end
      end
      checks++; if (multi_hot !== 0) begin errors++; $display("FAIL onehot got %0d overlapping cycles need 0", multi_hot); end
      $display("test_random %0d events %0d pulses expected", evt_q.size(), exp_q.size());
   endtask

   initial begin
      reset = 1'b1;
      press_in = 1'b0;
      test_reset();
      test_single();
      test_double();
      test_triple();
      test_coincide();
      test_reset_mid();
      test_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/click_classifier.md
CLICK_CLASSIFIER -- requirements
Module: click_classifier

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, clk frequency in Hz.
REQ-002 Parameter WINDOW_MS, default 400, inter-click window in ms; WINDOW_CYCLES = CLK_FREQ/1000*WINDOW_MS, at least 2.
REQ-003 Parameter MAX_CLICKS, default 3, click count that forces immediate classification; fixed at 3 in this revision.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 press_in  in  1  debounced press pulse from the button debouncer; asynchronous to clk; high for at least 2 clk cycles.
REQ-007 single_o  out  1  one-cycle pulse, one click classified.
REQ-008 double_o  out  1  one-cycle pulse, two clicks classified.
REQ-009 triple_o  out  1  one-cycle pulse, three clicks classified.
REQ-010 busy_o  out  1  high while a click sequence is open (state COUNTING).
REQ-011 count_o  out  2  clicks accumulated in the open sequence; 0 in IDLE.

Function
REQ-012 press_in SHALL pass through a 2-flop synchronizer, then a rising-edge detector; each detected edge is one press event, 3 clk after the press_in rise.
REQ-013 A press_in held high for any duration SHALL yield exactly one event.
REQ-014 FSM states SHALL be IDLE and COUNTING only.
REQ-015 IDLE + event: go to COUNTING, count=1, timer=WINDOW_CYCLES-1.
REQ-016 COUNTING + event with count<MAX_CLICKS-1: count+1, timer reloaded to WINDOW_CYCLES-1.
REQ-017 COUNTING + event with count=MAX_CLICKS-1: triple_o high next cycle, count=0, go to IDLE; no timeout wait.
REQ-018 COUNTING, no event: timer decrements by 1 per clk.
REQ-019 COUNTING, no event, timer=0: emit single_o (count=1) or double_o (count=2) next cycle, count=0, go to IDLE.
REQ-020 Event and timer=0 in the same cycle: the event wins; it is counted per REQ-016/017 and no timeout classification occurs.
REQ-021 The timer SHALL be sized $clog2(WINDOW_CYCLES) bits and SHALL never wrap below 0.
REQ-022 Outputs SHALL be registered; at most one of single_o/double_o/triple_o is high in any cycle; each pulse lasts exactly 1 clk.
REQ-023 An event in the cycle a classification pulse is emitted (state returning to IDLE) SHALL open a new sequence with count=1; it is not lost.
REQ-024 Sequence length from first event to single_o SHALL be exactly WINDOW_CYCLES+1 clk.

Reset
REQ-025 While reset is high: state IDLE, count 0, timer 0, synchronizer and edge flops 0, all outputs 0.
REQ-026 Reset asserted mid-sequence SHALL discard the sequence with no classification pulse, including after release.
REQ-027 If press_in is high at reset release, no event SHALL be produced until press_in falls and rises again.

Structure
REQ-028 The state encoding (IDLE, COUNTING) and the click-count width constant SHALL live in the shared utilities package.
REQ-029 The synchronizer plus edge detector SHALL be one sub-module, sync_edge_detect, reusable by other button consumers.
REQ-030 WINDOW_CYCLES SHALL be a localparam computed from the parameters; no runtime-configurable window.

Verification (CLK_FREQ=1000, WINDOW_MS=10, so WINDOW_CYCLES=10)
REQ-031 One press_in pulse, 5 clk wide -> single_o exactly once, 3+10+1 clk after the press_in rise; busy_o high for 11 clk.
REQ-032 Two pulses with rises 6 clk apart -> double_o once, single_o never; count_o shows 1 then 2.
REQ-033 Three pulses with rises 6 clk apart -> triple_o 1 clk after the third event, with no timeout wait; busy_o low the following cycle.
REQ-034 Second press_in rise timed so that its event coincides with timer=0 -> counted; double_o after a further window, no single_o.
REQ-035 Reset asserted 4 clk after the first event -> no output pulses ever; count_o=0; a fresh press after release gives single_o.
REQ-036 press_in held high for 50 clk -> single_o exactly once; press_in high at reset release -> no pulse.
